sd_cmd_resp_rx: RTL and testbench
=================================

SD_CMD_RESP_RX -- requirements
Module: sd_cmd_resp_rx

Interface
REQ-001 SHALL have parameter TIMEOUT_STROBES, default 64: sample strobes (SD clock rising edges) allowed between arm and the start bit.
REQ-002 SHALL have port clk, input, 1: single system clock; every register is clocked on its rising edge.
REQ-003 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port sd_clk_rise, input, 1: one-clk strobe marking the SD clock rising edge, i.e. the CMD sample point.
REQ-005 SHALL have port cmd_in, input, 1: CMD line as seen by the host once the host tristate is released.
REQ-006 SHALL have port arm, input, 1: one-clk pulse that starts listening for a response.
REQ-007 SHALL have port long_resp, input, 1: frame length select, sampled with arm; 1 = 136-bit R2, 0 = 48-bit frame.
REQ-008 SHALL have port crc_check, input, 1: CRC check enable, sampled with arm; 0 for R3/R4, whose CRC field is all ones.
REQ-009 SHALL have port busy, output, 1: high from the cycle after an accepted arm until done.
REQ-010 SHALL have port done, output, 1: one-clk pulse at the end of reception or at timeout.
REQ-011 SHALL have port resp, output, 136: received frame, MSB = first bit on the line.
REQ-012 SHALL have port timeout, crc_err, tx_err, end_err, each output, 1: status flags, valid from done.

Function
REQ-013 SHALL implement states IDLE, WAIT_START, RECEIVE and DONE.
REQ-014 SHALL go IDLE->WAIT_START on arm while in IDLE; arm in any other state SHALL be ignored.
REQ-015 SHALL on an accepted arm clear timeout, crc_err, tx_err, end_err and resp, and clear the strobe counter and the CRC register.
REQ-016 SHALL, when arm and sd_clk_rise coincide, not use that strobe; the first sample SHALL be taken at the next strobe.
REQ-017 SHALL sample cmd_in only on clk cycles where sd_clk_rise=1, in every state.
REQ-018 SHALL, in WAIT_START, move to RECEIVE with bit count 1 when a strobe sees cmd_in=0; that start bit SHALL be shifted in.
REQ-019 SHALL, in WAIT_START, count each strobe that sees cmd_in=1; when the count reaches TIMEOUT_STROBES it SHALL set timeout=1 and enter DONE.
REQ-020 SHALL, in RECEIVE, shift each sampled bit into resp from the LSB end, MSB-first, until 48 or 136 bits (per long_resp) have been taken.
REQ-021 SHALL right-align a 48-bit frame in resp[47:0], with resp[135:48]=0.
REQ-022 SHALL compute CRC7 serially with polynomial x^7+x^3+1 and initial value 0.
REQ-023 SHALL feed the CRC over frame bits 47..8 for a short frame, and over bits 127..8 for a long frame (start, transmission and reserved bits excluded).
REQ-024 SHALL set tx_err=1 if the transmission bit (frame bit 46, or 134 for a long frame) is 1.
REQ-025 SHALL set end_err=1 if frame bit 0 is 0.
REQ-026 SHALL set crc_err=1 if crc_check=1 and frame bits 7..1 differ from the computed CRC7; with crc_check=0, crc_err SHALL stay 0.
REQ-027 SHALL enter DONE in the clk cycle after the strobe that samples the last bit.
REQ-028 SHALL hold done=1 for exactly one clk while in DONE, then return to IDLE.
REQ-029 SHALL hold resp and all flags stable from done until the next accepted arm.
REQ-030 SHALL make busy and done registered outputs, with no combinational path from any input.

Reset
REQ-031 SHALL, while rst=0 and independent of clk, force: state IDLE; busy, done, timeout, crc_err, tx_err, end_err = 0; resp = 0; counters and CRC = 0.
REQ-032 SHALL, on reset mid-reception, abandon the frame with no done pulse, and accept an arm in the first clk after rst is released.

Structure
REQ-033 SHALL take the state encoding, the frame lengths 48/136 and the CRC7 polynomial 0x09 from a shared package sd_pkg, also used by the command transmitter.
REQ-034 SHALL implement CRC7 in one sub-module, sd_crc7 (inputs: enable, clear, data bit; output: 7-bit CRC), reusable by the transmitter.

Verification
REQ-035 SHALL cover: arm, short, crc_check=1, frame 0x000000000001 -> done, resp[47:0]=0x000000000001, all flags 0.
REQ-036 SHALL cover: arm, short, crc_check=1, frame 0x400000000095 -> tx_err=1, crc_err=0, end_err=0.
REQ-037 SHALL cover: arm, short, crc_check=0, R4 frame 0x3F90FF8000FF -> crc_err=0, tx_err=0, resp[47:0]=0x3F90FF8000FF.
REQ-038 SHALL cover: the REQ-035 frame with bit 20 flipped, crc_check=1 -> crc_err=1; a frame ending in 0 -> end_err=1.
REQ-039 SHALL cover: cmd_in held 1 for 64 strobes -> timeout=1 with done on the 64th strobe +1 clk; 63 idle strobes then a start bit -> normal reception.
REQ-040 SHALL cover: long frame with a valid CRC over bits 127..8 -> flags 0 and resp = the full 136 bits; rst pulsed at bit 70 -> no done, then a clean re-arm.

Source files
------------

// File: rtl/sd_pkg.sv
// Shared SD command-path definitions: FSM encoding, frame lengths and CRC7 helpers
// used by both the command transmitter and the response receiver.
package sd_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_START = 2'd1,
    RECEIVE    = 2'd2,
    DONE       = 2'd3
  } sd_state_e;

  localparam int unsigned SHORT_LEN = 48;
  localparam int unsigned LONG_LEN  = 136;
  localparam logic [6:0]  CRC7_POLY = 7'h09;  // x^7 + x^3 + 1

  // One serial CRC7 step, MSB-first.
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'd0);
  endfunction

  // True when frame bit idx is protected by the CRC: 47..8 short, 127..8 long.
  function automatic logic crc7_covers(input logic long_frame, input logic [7:0] idx);
    return (idx >= 8'd8) && (idx <= (long_frame ? 8'd127 : 8'd47));
  endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 generator/checker, shared by the SD command transmitter and receiver.
module sd_crc7
  import sd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  input  logic       din,
  output logic [6:0] crc
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // updates from pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      crc <= 7'd0;
    else if (clr)  crc <= 7'd0;
    else if (en)   crc <= crc7_step(crc, din);
  end

endmodule

// File: rtl/sd_cmd_resp_rx.sv
// SD CMD-line response receiver: waits for a start bit, shifts in a 48- or 136-bit
// frame at SD clock rising-edge strobes, and reports timeout/CRC/framing status.
module sd_cmd_resp_rx
  import sd_pkg::*;
#(
  parameter int unsigned TIMEOUT_STROBES = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sd_clk_rise,
  input  logic         cmd_in,
  input  logic         arm,
  input  logic         long_resp,
  input  logic         crc_check,
  output logic         busy,
  output logic         done,
  output logic [135:0] resp,
  output logic         timeout,
  output logic         crc_err,
  output logic         tx_err,
  output logic         end_err
);

  localparam int unsigned     TO_W       = $clog2(TIMEOUT_STROBES + 1);
  localparam logic [TO_W-1:0] TO_LAST    = TO_W'(TIMEOUT_STROBES - 1);
  localparam logic [7:0]      SHORT_LAST = 8'(SHORT_LEN - 1);
  localparam logic [7:0]      LONG_LAST  = 8'(LONG_LEN - 1);

  sd_state_e         state_q, state_d;
  logic              busy_d, done_d;
  logic [135:0]      resp_d;
  logic              timeout_d, crc_err_d, tx_err_d, end_err_d;
  logic              long_q, long_d, check_q, check_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [7:0]        bit_cnt_q, bit_cnt_d;
  logic [6:0]        crc;
  logic              crc_en, crc_clr;
  logic [135:0]      shifted;
  logic [7:0]        frame_last, sample_idx;

  assign shifted    = {resp[134:0], cmd_in};
  assign frame_last = long_q ? LONG_LAST : SHORT_LAST;
  // Frame bit index of the bit being sampled at this strobe while in RECEIVE.
  assign sample_idx = frame_last - bit_cnt_q;

  sd_crc7 u_crc7 (
    .clk (clk),
    .rst (rst),
    .en  (crc_en),
    .clr (crc_clr),
    .din (cmd_in),
    .crc (crc)
  );

  // NOTE: every signal is given its hold value first, so no path through this
  // block can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    busy_d    = busy;
    done_d    = 1'b0;
    resp_d    = resp;
    timeout_d = timeout;
    crc_err_d = crc_err;
    tx_err_d  = tx_err;
    end_err_d = end_err;
    long_d    = long_q;
    check_d   = check_q;
    to_cnt_d  = to_cnt_q;
    bit_cnt_d = bit_cnt_q;
    crc_en    = 1'b0;
    crc_clr   = 1'b0;

    case (state_q)
      IDLE: begin
        // A strobe coinciding with arm falls here and is deliberately unused.
        if (arm) begin
          state_d   = WAIT_START;
          busy_d    = 1'b1;
          long_d    = long_resp;
          check_d   = crc_check;
          resp_d    = '0;
          timeout_d = 1'b0;
          crc_err_d = 1'b0;
          tx_err_d  = 1'b0;
          end_err_d = 1'b0;
          to_cnt_d  = '0;
          bit_cnt_d = '0;
          crc_clr   = 1'b1;
        end
      end

      WAIT_START: begin
        if (sd_clk_rise) begin
          if (!cmd_in) begin
            state_d   = RECEIVE;
            bit_cnt_d = 8'd1;
            resp_d    = shifted;
            crc_en    = crc7_covers(long_q, frame_last);
          end else if (to_cnt_q == TO_LAST) begin
            state_d   = DONE;
            done_d    = 1'b1;
            timeout_d = 1'b1;
          end else begin
            to_cnt_d  = to_cnt_q + 1'b1;
          end
        end
      end

      RECEIVE: begin
        if (sd_clk_rise) begin
          resp_d    = shifted;
          bit_cnt_d = bit_cnt_q + 8'd1;
          crc_en    = crc7_covers(long_q, sample_idx);
          if (sample_idx == 8'd0) begin
            // The CRC register already holds the result: bit 8 was its last input.
            state_d   = DONE;
            done_d    = 1'b1;
            end_err_d = ~cmd_in;
            tx_err_d  = long_q ? shifted[134] : shifted[46];
            crc_err_d = check_q && (shifted[7:1] != crc);
          end
        end
      end

      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: resp is a plain register bank, not a memory, so it is reset along
  // with everything else to give a defined all-zero frame out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      resp      <= '0;
      timeout   <= 1'b0;
      crc_err   <= 1'b0;
      tx_err    <= 1'b0;
      end_err   <= 1'b0;
      long_q    <= 1'b0;
      check_q   <= 1'b0;
      to_cnt_q  <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      busy      <= busy_d;
      done      <= done_d;
      resp      <= resp_d;
      timeout   <= timeout_d;
      crc_err   <= crc_err_d;
      tx_err    <= tx_err_d;
      end_err   <= end_err_d;
      long_q    <= long_d;
      check_q   <= check_d;
      to_cnt_q  <= to_cnt_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

endmodule

// File: tb/tb_sd_cmd_resp_rx.sv
// Bench for sd_cmd_resp_rx: table of response frames plus hand-written timeout,
// arm/strobe collision and mid-frame reset sequences, checked through a scoreboard.
module tb_sd_cmd_resp_rx;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         sd_clk_rise = 1'b0;
  logic         cmd_in = 1'b1;
  logic         arm = 1'b0;
  logic         long_resp = 1'b0;
  logic         crc_check = 1'b0;
  logic         busy, done;
  logic [135:0] resp;
  logic         timeout, crc_err, tx_err, end_err;

  sd_cmd_resp_rx #(.TIMEOUT_STROBES(64)) dut (
    .clk         (clk),
    .rst         (rst),
    .sd_clk_rise (sd_clk_rise),
    .cmd_in      (cmd_in),
    .arm         (arm),
    .long_resp   (long_resp),
    .crc_check   (crc_check),
    .busy        (busy),
    .done        (done),
    .resp        (resp),
    .timeout     (timeout),
    .crc_err     (crc_err),
    .tx_err      (tx_err),
    .end_err     (end_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [135:0] resp;
    logic         timeout, crc_err, tx_err, end_err;
  } exp_t;

  typedef struct {
    logic         long_r;
    logic         chk;
    int           idle;
    logic [135:0] frame;
    logic         exp_crc, exp_tx, exp_end;
    logic         arm_on_strobe;
    logic         arm_mid;
  } vec_t;

  exp_t  exp_q[$];
  exp_t  mon_e;
  int    n_cmp = 0;
  int    n_err = 0;
  int    done_cnt = 0;
  logic  prev_done = 1'b0;
  string cur_tag = "reset";

  task automatic check(input string name, input logic [135:0] act, input logic [135:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Reference CRC7 by polynomial long division of M(x)*x^7 by 0x89.
  function automatic logic [6:0] ref_crc7(input logic [135:0] f, input int hi, input int lo);
    logic [7:0] r;
    r = 8'd0;
    for (int i = hi; i >= lo - 7; i--) begin
      r = {r[6:0], (i >= lo) ? f[i] : 1'b0};
      if (r[7]) r = r ^ 8'h89;
    end
    return r[6:0];
  endfunction

  function automatic vec_t mk(input logic l, input logic c, input int idle, input logic [135:0] f,
                              input logic ec, input logic et, input logic ee,
                              input logic aos, input logic am);
    vec_t v;
    v.long_r = l; v.chk = c; v.idle = idle; v.frame = f;
    v.exp_crc = ec; v.exp_tx = et; v.exp_end = ee;
    v.arm_on_strobe = aos; v.arm_mid = am;
    return v;
  endfunction

  // Scoreboard consumer: every done pulse pops one expected result.
  always @(negedge clk) begin
    if (done) begin
      check($sformatf("%s.done_width", cur_tag), prev_done, 1'b0);
      if (exp_q.size() == 0) begin
        check($sformatf("%s.unexpected_done", cur_tag), done, 1'b0);
      end else begin
        mon_e = exp_q.pop_front();
        check($sformatf("%s.resp", cur_tag),    resp,    mon_e.resp);
        check($sformatf("%s.timeout", cur_tag), timeout, mon_e.timeout);
        check($sformatf("%s.crc_err", cur_tag), crc_err, mon_e.crc_err);
        check($sformatf("%s.tx_err", cur_tag),  tx_err,  mon_e.tx_err);
        check($sformatf("%s.end_err", cur_tag), end_err, mon_e.end_err);
      end
      done_cnt++;
    end
    prev_done <= done;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic b);
    cmd_in = b;
    sd_clk_rise = 1'b1;
    tick();
    sd_clk_rise = 1'b0;
    cmd_in = 1'b1;
    tick();
    tick();
  endtask

  // Mode inputs are flipped after the arm cycle so only the captured values matter.
  task automatic do_arm(input logic l, input logic c, input logic with_strobe, input logic sval);
    arm = 1'b1;
    long_resp = l;
    crc_check = c;
    sd_clk_rise = with_strobe;
    cmd_in = with_strobe ? sval : 1'b1;
    tick();
    arm = 1'b0;
    sd_clk_rise = 1'b0;
    cmd_in = 1'b1;
    long_resp = ~l;
    crc_check = ~c;
    tick();
  endtask

  task automatic wait_done(input int c0, input string tag);
    for (int k = 0; k < 10 && done_cnt == c0; k++) tick();
    check($sformatf("%s.done_seen", tag), done_cnt != c0, 1'b1);
  endtask

  task automatic send_frame(input vec_t v, input string tag);
    exp_t e;
    int   len;
    int   c0;
    len = v.long_r ? 136 : 48;
    e.resp = v.frame;
    e.timeout = 1'b0;
    e.crc_err = v.exp_crc;
    e.tx_err = v.exp_tx;
    e.end_err = v.exp_end;
    exp_q.push_back(e);
    cur_tag = tag;
    do_arm(v.long_r, v.chk, v.arm_on_strobe, 1'b0);
    check($sformatf("%s.busy_after_arm", tag), busy, 1'b1);
    c0 = done_cnt;
    repeat (v.idle) strobe(1'b1);
    for (int i = len - 1; i >= 0; i--) begin
      if (i == 0) begin
        cmd_in = v.frame[0];
        sd_clk_rise = 1'b1;
        tick();
        sd_clk_rise = 1'b0;
        cmd_in = 1'b1;
        check($sformatf("%s.done_timing", tag), done, 1'b1);
        tick();
        tick();
      end else begin
        strobe(v.frame[i]);
      end
      if (v.arm_mid && i == len - 10) begin
        arm = 1'b1;
        long_resp = ~v.long_r;
        crc_check = ~v.chk;
        tick();
        arm = 1'b0;
      end
    end
    wait_done(c0, tag);
    repeat (3) tick();
    check($sformatf("%s.resp_hold", tag), resp, v.frame);
    check($sformatf("%s.busy_idle", tag), busy, 1'b0);
  endtask

  vec_t         vecs[11];
  logic [135:0] lg, lg_bad;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running, expected finished");
    $fatal(1);
  end

  initial begin
    exp_t e;
    int   c0;

    lg = {8'h3F, 120'h035344534430303010AABBCCDD0142, 7'h00, 1'b1};
    lg[7:1] = ref_crc7(lg, 127, 8);
    lg_bad = lg;
    lg_bad[60] = ~lg_bad[60];

    //             long chk idle frame                    crc tx end aos mid
    vecs[0]  = mk(0, 1, 3,  136'h000000000001,          0, 0, 0, 0, 0);
    vecs[1]  = mk(0, 1, 0,  136'h400000000095,          0, 1, 0, 0, 0);
    vecs[2]  = mk(0, 0, 5,  136'h3F90FF8000FF,          0, 0, 0, 0, 0);
    vecs[3]  = mk(0, 1, 2,  136'h000000100001,          1, 0, 0, 0, 0);
    vecs[4]  = mk(0, 1, 1,  136'h000000000000,          0, 0, 1, 0, 0);
    vecs[5]  = mk(0, 0, 1,  136'h000000100001,          0, 0, 0, 0, 0);
    vecs[6]  = mk(0, 1, 63, 136'h000000000001,          0, 0, 0, 0, 0);
    vecs[7]  = mk(0, 1, 2,  136'h770000000065,          0, 1, 0, 1, 0);
    vecs[8]  = mk(1, 1, 4,  lg,                         0, 0, 0, 0, 1);
    vecs[9]  = mk(1, 1, 0,  lg_bad,                     1, 0, 0, 0, 0);
    vecs[10] = mk(0, 1, 2,  136'h48000001AA87,          0, 1, 0, 0, 1);

    // Reset state, asserted from time 0 with no arm.
    repeat (2) tick();
    check("reset.busy",    busy,    1'b0);
    check("reset.done",    done,    1'b0);
    check("reset.resp",    resp,    136'd0);
    check("reset.timeout", timeout, 1'b0);
    check("reset.crc_err", crc_err, 1'b0);
    check("reset.tx_err",  tx_err,  1'b0);
    check("reset.end_err", end_err, 1'b0);
    rst = 1'b1;
    tick();

    foreach (vecs[i]) send_frame(vecs[i], $sformatf("vec%0d", i));

    // Timeout: 63 idle strobes give nothing, the 64th produces done next clk.
    cur_tag = "timeout";
    e.resp = '0; e.timeout = 1'b1; e.crc_err = 1'b0; e.tx_err = 1'b0; e.end_err = 1'b0;
    exp_q.push_back(e);
    do_arm(1'b0, 1'b1, 1'b0, 1'b0);
    c0 = done_cnt;
    repeat (63) strobe(1'b1);
    check("timeout.no_done_at_63", done_cnt != c0, 1'b0);
    check("timeout.busy_at_63", busy, 1'b1);
    cmd_in = 1'b1;
    sd_clk_rise = 1'b1;
    tick();
    sd_clk_rise = 1'b0;
    check("timeout.done_at_64", done, 1'b1);
    check("timeout.flag_at_64", timeout, 1'b1);
    tick();
    tick();
    wait_done(c0, "timeout");

    // Reset at bit 70 of a long frame: no done, then an arm right after release.
    cur_tag = "reset_mid";
    do_arm(1'b1, 1'b1, 1'b0, 1'b0);
    c0 = done_cnt;
    for (int i = 135; i > 65; i--) strobe(lg[i]);
    rst = 1'b0;
    #1;
    check("reset_mid.busy_async", busy, 1'b0);
    check("reset_mid.resp_async", resp, 136'd0);
    repeat (3) tick();
    check("reset_mid.no_done", done_cnt != c0, 1'b0);
    rst = 1'b1;
    send_frame(vecs[8], "rearm");

    check("scoreboard.drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
